seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit hex 7-segment display driver; successor to the single-digit combinational hex decoder.
- Holds a DIGITS-nibble value and scans one digit per slot on common-anode displays.
- Adds registered outputs, tear-free frame-boundary updates, anti-ghost blanking, leading-zero suppression and decimal points.

Parameters:
- DIGITS, 4: number of digits; value width 4*DIGITS; range 1..8.
- PRESCALE, 1000: clocks per digit slot; must be at least 2.
- BLANK_CYC, 2: clocks at the start of each slot with all anodes off; range 0..PRESCALE-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan and drive; 0 = display dark.
- load  in  1  one-cycle strobe that captures value/dp_in into the pending register.
- value  in  4*DIGITS  hex digits; nibble i (value[4i+3:4i]) goes to digit i; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg7  out  7  active-low segments, seg7[6:0] = {a,b,c,d,e,f,g}.
- dp_n  out  1  active-low decimal point.
- an  out  DIGITS  active-low digit enables; an[i] drives digit i.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, active-high): seg7=7'b1111111, dp_n=1, an all 1, frame_done=0. Slot counter cnt=0, digit index idx=0, display reg=0, pending reg=0, pending_valid=0.
- Counters: cnt counts 0..PRESCALE-1 every clock and wraps to 0.
  - At cnt==PRESCALE-1, idx advances, wrapping DIGITS-1 -> 0.
  - Counters run regardless of enable.
- Frame boundary: the cycle where cnt==PRESCALE-1 and idx==DIGITS-1.
  - If pending_valid, display reg <= pending and pending_valid <= 0.
  - frame_done pulses on every boundary, whether or not a commit occurs.
- load: pending <= {value, dp_in}, pending_valid <= 1. The display never changes mid-frame, so there is no tearing.
  - Multiple loads within a frame: last one wins.
  - load in the boundary cycle: the commit uses the pending contents from before that edge. The new value stays pending (pending_valid=1) and commits at the next boundary.
- Encoding (active low, per nibble):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero suppression (blank_lz=1): digit i>0 is blanked (seg7=1111111) when nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp and still asserts its anode.
- Output function:
  - enable=0 or cnt<BLANK_CYC: an all 1, seg7=1111111, dp_n=1.
  - Otherwise: an has only bit idx low; seg7 = decode(display nibble idx) with suppression applied; dp_n = ~dp bit idx.
- Latency: all outputs are registered and lag (cnt, idx, display reg) by exactly one clock.
- Mid-operation reset: all outputs go dark immediately (asynchronous) and any pending value is discarded.

Test Plan (DIGITS=4, PRESCALE=4, BLANK_CYC=1):
1. Hold reset, then release. Required: seg7=1111111, an=1111, dp_n=1, frame_done=0. First frame_done occurs 16 clocks after release, with a display of 0 (blank_lz=0): every digit shows 0000001.
2. load value=16'h9Ab8, dp_in=0, then wait for the commit. Per slot, after the blank cycle:
   - an=1110, seg7=0000000
   - an=1101, seg7=1100000
   - an=1011, seg7=0001000
   - an=0111, seg7=0000100
   - dp_n=1 throughout.
3. blank_lz=1, load 16'h0008 -> digits 3..1 show seg7=1111111 with their anodes asserted, digit 0 shows 0000000. Then load 16'h0000 -> digit 0 shows 0000001.
4. load 16'h1234 mid-frame while 16'hFFFF is displayed -> the remaining slots of that frame still show F=0111000. 1/2/3/4 appear only after frame_done. A load in the boundary cycle is deferred one full frame.
5. dp_in=4'b0100 -> dp_n=0 only during digit 2 slots. Drop enable -> an=1111, seg7=1111111, dp_n=1 one clock later.
6. Assert reset mid-slot with a pending load -> outputs go dark asynchronously. After release, the display shows 0 and the pending value never appears.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus between a host and the multiplexed 7-segment scan driver.
// The host drives the display value and control inputs, and the driver returns the segment, anode and frame signals.
`timescale 1ns/1ps

// load is a single-cycle strobe that is always accepted, so there is no ready.
// Each load overwrites the pending value, and the last load before a frame boundary wins.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [6:0]            seg7;
    logic                  dp_n;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output enable, load, value, dp_in, blank_lz,
        input  seg7, dp_n, an, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, blank_lz,
        output seg7, dp_n, an, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex driver for common-anode displays. A new value is committed only at a
// frame boundary, and each slot begins with anti-ghost blanking. All outputs are registered.
`timescale 1ns/1ps

module seg7_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_disp_val;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_valid;
    logic [6:0]          r_seg7;
    logic                r_dp_n;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame_done;

    logic                w_slot_end;
    logic                w_boundary;
    logic [DIGITS-1:0]   w_zero_above;
    logic [3:0]          w_nib;
    logic                w_lz_blank;
    logic                w_show;
    logic [6:0]          w_seg_nx;
    logic                w_dp_nx;
    logic [DIGITS-1:0]   w_an_nx;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign w_slot_end = (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

    // The scan counters free-run even while the display is disabled.
    // This keeps the frame_done cadence independent of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load in the boundary cycle still lands in pending. The commit on that edge uses the older contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (bus.load) begin
            r_pend_val   <= bus.value;
            r_pend_dp    <= bus.dp_in;
            r_pend_valid <= 1'b1;
        end else if (w_boundary) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
        end else if (w_boundary && r_pend_valid) begin
            r_disp_val <= r_pend_val;
            r_disp_dp  <= r_pend_dp;
        end
    end

    // w_zero_above[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        logic v_zero;
        v_zero       = 1'b1;
        w_zero_above = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_zero          = v_zero & (r_disp_val[4*i +: 4] == 4'h0);
            w_zero_above[i] = v_zero;
        end
    end

    always_comb begin
        w_nib      = r_disp_val[{r_idx, 2'b00} +: 4];
        w_lz_blank = bus.blank_lz && (r_idx != '0) && w_zero_above[r_idx];
        w_show     = bus.enable && (r_cnt >= BLANK_END);
        w_an_nx    = '1;
        w_seg_nx   = 7'b1111111;
        w_dp_nx    = 1'b1;
        if (w_show) begin
            w_an_nx[r_idx] = 1'b0;
            w_seg_nx       = w_lz_blank ? 7'b1111111 : f_decode(w_nib);
            w_dp_nx        = ~r_disp_dp[r_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg7       <= 7'b1111111;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg7       <= w_seg_nx;
            r_dp_n       <= w_dp_nx;
            r_an         <= w_an_nx;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.seg7       = r_seg7;
    assign bus.dp_n       = r_dp_n;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, PRESCALE=4, BLANK_CYC=1. A time-indexed display model
// predicts every output cycle. Directed scenarios pin known patterns, and a random tail follows them.
`timescale 1ns/1ps

module tb_seg7_scan_driver;
  localparam int DIGITS    = 4;
  localparam int PRESCALE  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * PRESCALE;
  localparam int EW        = DIGITS + 7 + 1 + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus();

  seg7_scan_driver #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset block ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [EW-1:0]        exp_q[$];
  int                   m_t;
  logic [4*DIGITS-1:0]  m_disp_v, m_pend_v, m_upper;
  logic [DIGITS-1:0]    m_disp_dp, m_pend_dp, m_an;
  logic [6:0]           m_seg;
  logic                 m_dp;
  bit                   m_pv, m_bnd;
  int                   m_pos, m_dig;

  // The model counts cycles since reset release. The slot, digit and boundary come from integer division.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_t = 0; m_disp_v = '0; m_disp_dp = '0; m_pend_v = '0; m_pend_dp = '0; m_pv = 0;
      exp_q.delete();
      exp_q.push_back({{DIGITS{1'b1}}, 7'b1111111, 1'b1, 1'b0});
    end else begin
      m_pos = m_t % PRESCALE;
      m_dig = (m_t / PRESCALE) % DIGITS;
      m_bnd = (m_t % FRAME) == FRAME - 1;
      m_an = '1; m_seg = 7'b1111111; m_dp = 1'b1;
      if (bus.enable && m_pos >= BLANK_CYC) begin
        m_an = ~(DIGITS'(1) << m_dig);
        m_upper = m_disp_v >> (4 * m_dig);
        if (bus.blank_lz && m_dig > 0 && m_upper == 0) m_seg = 7'b1111111;
        else m_seg = seg_tab[m_upper[3:0]];
        m_dp = ~m_disp_dp[m_dig];
      end
      exp_q.push_back({m_an, m_seg, m_dp, m_bnd});
      if (m_bnd && m_pv) begin
        m_disp_v = m_pend_v; m_disp_dp = m_pend_dp; m_pv = 0;
      end
      if (bus.load) begin
        m_pend_v = bus.value; m_pend_dp = bus.dp_in; m_pv = 1;
      end
      m_t++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  logic [EW-1:0] sb_w;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_queue act=empty exp=entry t=%0t", $time);
      end else begin
        sb_w = exp_q.pop_front();
        chk("sb_an",   32'(bus.an),         32'(sb_w[EW-1 -: DIGITS]));
        chk("sb_seg7", 32'(bus.seg7),       32'(sb_w[8:2]));
        chk("sb_dp_n", 32'(bus.dp_n),       32'(sb_w[1]));
        chk("sb_fd",   32'(bus.frame_done), 32'(sb_w[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [DIGITS-1:0] cap_an  [FRAME+1];
  logic [6:0]        cap_seg [FRAME+1];
  logic              cap_dp  [FRAME+1];

  task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] dp);
    bus.load = 1'b1; bus.value = v; bus.dp_in = dp;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 64);
    if (bus.frame_done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL frame_done_timeout act=%0d exp=<64 cycles", n);
    end
  endtask

  // Called at a frame_done negedge (offset 0). It records offsets 1..FRAME and so ends at the next one.
  task automatic capture();
    for (int o = 1; o <= FRAME; o++) begin
      @(negedge clk);
      cap_an[o] = bus.an; cap_seg[o] = bus.seg7; cap_dp[o] = bus.dp_n;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  int n;
  initial begin
    bus.enable = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg7", 32'(bus.seg7), 32'h7F);
    chk("rst_an",   32'(bus.an),   32'hF);
    chk("rst_dp_n", 32'(bus.dp_n), 32'h1);
    chk("rst_fd",   32'(bus.frame_done), 32'h0);
    reset = 1'b0;

    // Reset frame: zero on every digit
    wait_fd(n);
    chk("first_fd_latency", 32'(n), 32'd16);
    capture();
    chk("zero_d0_an",   32'(cap_an[2]),   32'b1110);
    chk("zero_d0_seg",  32'(cap_seg[2]),  32'b0000001);
    chk("zero_d3_seg",  32'(cap_seg[14]), 32'b0000001);
    chk("zero_blank",   32'(cap_an[1]),   32'b1111);

    // 9Ab8
    do_load(16'h9AB8, 4'b0000);
    wait_fd(n);
    capture();
    chk("hex_d0_an",  32'(cap_an[2]),   32'b1110);
    chk("hex_d0_seg", 32'(cap_seg[2]),  32'b0000000);
    chk("hex_d1_an",  32'(cap_an[6]),   32'b1101);
    chk("hex_d1_seg", 32'(cap_seg[6]),  32'b1100000);
    chk("hex_d2_an",  32'(cap_an[10]),  32'b1011);
    chk("hex_d2_seg", 32'(cap_seg[10]), 32'b0001000);
    chk("hex_d3_an",  32'(cap_an[14]),  32'b0111);
    chk("hex_d3_seg", 32'(cap_seg[14]), 32'b0000100);
    chk("hex_dp_n",   32'(cap_dp[14]),  32'h1);

    // Leading-zero suppression
    bus.blank_lz = 1'b1;
    do_load(16'h0008, 4'b0000);
    wait_fd(n);
    capture();
    chk("lz_d3_seg", 32'(cap_seg[14]), 32'b1111111);
    chk("lz_d3_an",  32'(cap_an[14]),  32'b0111);
    chk("lz_d0_seg", 32'(cap_seg[2]),  32'b0000000);
    do_load(16'h0000, 4'b0000);
    wait_fd(n);
    capture();
    chk("lz0_d0_seg", 32'(cap_seg[2]), 32'b0000001);
    chk("lz0_d1_seg", 32'(cap_seg[6]), 32'b1111111);

    // Tear-free update, then a load in the boundary cycle
    bus.blank_lz = 1'b0;
    do_load(16'hFFFF, 4'b0000);
    wait_fd(n);
    repeat (5) @(negedge clk);
    do_load(16'h1234, 4'b0000);
    repeat (4) @(negedge clk);
    chk("tear_d2_an",  32'(bus.an),   32'b1011);
    chk("tear_d2_seg", 32'(bus.seg7), 32'b0111000);
    repeat (6) @(negedge clk);
    chk("tear_fd", 32'(bus.frame_done), 32'h1);
    capture();
    chk("new_d0_seg", 32'(cap_seg[2]),  32'b1001100);
    chk("new_d3_seg", 32'(cap_seg[14]), 32'b1001111);
    repeat (FRAME - 1) @(negedge clk);
    do_load(16'h5678, 4'b0000);
    chk("bnd_fd", 32'(bus.frame_done), 32'h1);
    capture();
    chk("bnd_defer_d0", 32'(cap_seg[2]), 32'b1001100);
    capture();
    chk("bnd_late_d0", 32'(cap_seg[2]),  32'b0000000);
    chk("bnd_late_d3", 32'(cap_seg[14]), 32'b0100100);

    // Decimal point on digit 2, then enable drop
    do_load(16'h0000, 4'b0100);
    wait_fd(n);
    capture();
    chk("dp_d2",    32'(cap_dp[10]), 32'h0);
    chk("dp_d1",    32'(cap_dp[6]),  32'h1);
    chk("dp_blank", 32'(cap_dp[9]),  32'h1);
    repeat (10) @(negedge clk);
    chk("en_pre_an",  32'(bus.an),   32'b1011);
    chk("en_pre_dp",  32'(bus.dp_n), 32'h0);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_off_an",  32'(bus.an),   32'hF);
    chk("en_off_seg", 32'(bus.seg7), 32'h7F);
    chk("en_off_dp",  32'(bus.dp_n), 32'h1);
    bus.enable = 1'b1;

    // Asynchronous reset with a pending value
    wait_fd(n);
    do_load(16'hABCD, 4'b1111);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_an",   32'(bus.an),   32'hF);
    chk("async_seg",  32'(bus.seg7), 32'h7F);
    chk("async_dp",   32'(bus.dp_n), 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_fd(n);
    chk("rst2_fd_latency", 32'(n), 32'd16);
    capture();
    chk("rst2_d0_seg", 32'(cap_seg[2]),  32'b0000001);
    chk("rst2_d3_seg", 32'(cap_seg[14]), 32'b0000001);
    chk("rst2_d3_dp",  32'(cap_dp[14]),  32'h1);

    // Random tail
    for (int i = 0; i < 1500; i++) begin
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.value    = 16'($urandom);
      bus.dp_in    = 4'($urandom_range(0, 15));
      bus.enable   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0) bus.blank_lz = ~bus.blank_lz;
      @(negedge clk);
    end
    bus.load = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
